// File: rtl/axis_dest_demux_reg_if.sv
// Stream bundle for axis_dest_demux_reg: one AXI-Stream input, NMASTERS registered outputs.
// The slave modport is the demux's own view; master is the source/sink environment's view.
interface axis_dest_demux_reg_if #(
    parameter int NMASTERS   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 8,
    parameter int ID_WIDTH   = 1
);
    logic                           s_valid;
    logic                           s_ready;
    logic [DATA_WIDTH-1:0]          s_data;
    logic [DEST_WIDTH-1:0]          s_dest;
    logic [ID_WIDTH-1:0]            s_id;
    logic                           s_last;
    logic [NMASTERS-1:0]            m_valid;
    logic [NMASTERS-1:0]            m_ready;
    logic [NMASTERS*DATA_WIDTH-1:0] m_data;
    logic [NMASTERS*DEST_WIDTH-1:0] m_dest;
    logic [NMASTERS*ID_WIDTH-1:0]   m_id;
    logic [NMASTERS-1:0]            m_last;

    modport slave (
        input  s_valid, s_data, s_dest, s_id, s_last, m_ready,
        output s_ready, m_valid, m_data, m_dest, m_id, m_last
    );

    modport master (
        output s_valid, s_data, s_dest, s_id, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_dest, m_id, m_last
    );
endinterface

// File: rtl/axis_dest_demux_reg.sv
// TDEST-routed AXI-Stream demux with a one-beat register per output; routing is fixed per packet.
// Define AXIS_DEMUX_DROP_EN to discard packets matching no master instead of sending them to the last one.
module axis_dest_demux_reg #(
    parameter int NMASTERS    = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int DEST_WIDTH  = 8,
    parameter int ID_WIDTH    = 1,
    parameter int DEST_BASE   = 0,
    parameter int DEST_STRIDE = 1,
    parameter int DEST_RANGE  = 0
) (
    input logic                  aclk,
    input logic                  aresetn,
    axis_dest_demux_reg_if.slave bus
);
    localparam int SEL_W = $clog2(NMASTERS);

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t           state;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] dec_sel;
    logic             accept;
`ifdef AXIS_DEMUX_DROP_EN
    logic             dec_hit;
`endif

    function automatic logic dest_match(input logic [DEST_WIDTH-1:0] dest, input int idx);
        longint lo;
        longint d;
        lo = longint'(DEST_BASE) + longint'(idx) * longint'(DEST_STRIDE);
        d  = longint'({{(64-DEST_WIDTH){1'b0}}, dest});
        return (d >= lo) && (d <= lo + longint'(DEST_RANGE));
    endfunction

    // Scan downwards so the lowest matching index is the one left standing.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        dec_sel = SEL_W'(NMASTERS - 1);
`ifdef AXIS_DEMUX_DROP_EN
        dec_hit = 1'b0;
`endif
        for (int i = NMASTERS - 1; i >= 0; i--) begin
            if (dest_match(bus.s_dest, i)) begin
                dec_sel = SEL_W'(i);
`ifdef AXIS_DEMUX_DROP_EN
                dec_hit = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        bus.s_ready = 1'b0;
        case (state)
            ROUTE:   bus.s_ready = !bus.m_valid[sel] || bus.m_ready[sel];
`ifdef AXIS_DEMUX_DROP_EN
            DROP:    bus.s_ready = 1'b1;
`endif
            default: bus.s_ready = 1'b0;
        endcase
    end

    assign accept = (state == ROUTE) && bus.s_valid && bus.s_ready;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.s_valid) begin
                        sel <= dec_sel;
`ifdef AXIS_DEMUX_DROP_EN
                        state <= dec_hit ? ROUTE : DROP;
`else
                        state <= ROUTE;
`endif
                    end
                end
                ROUTE: begin
                    if (accept && bus.s_last) state <= IDLE;
                end
                DROP: begin
                    if (bus.s_valid && bus.s_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Each output register loads only from the selected master's accepted beat and
    // otherwise drains on its own ready, independent of what the input is doing.
    // NOTE: the payload registers are reset as well, since they are directly visible on the ports.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bus.m_valid <= '0;
            bus.m_data  <= '0;
            bus.m_dest  <= '0;
            bus.m_id    <= '0;
            bus.m_last  <= '0;
        end else begin
            for (int i = 0; i < NMASTERS; i++) begin
                if (accept && (sel == SEL_W'(i))) begin
                    bus.m_valid[i]                         <= 1'b1;
                    bus.m_data[i*DATA_WIDTH +: DATA_WIDTH] <= bus.s_data;
                    bus.m_dest[i*DEST_WIDTH +: DEST_WIDTH] <= bus.s_dest;
                    bus.m_id[i*ID_WIDTH +: ID_WIDTH]       <= bus.s_id;
                    bus.m_last[i]                          <= bus.s_last;
                end else if (bus.m_ready[i]) begin
                    bus.m_valid[i] <= 1'b0;
                end
            end
        end
    end
endmodule
